coax_bus_ctrl: RTL and testbench
================================

// Module: coax_bus_ctrl
//
// PURPOSE
// Owns the shared 10-bit host data bus between an external MCU and the coax receive/transmit datapaths.
// Drains received words from coax_rx into a small FIFO and presents them to the host on read strobes.
// Captures host-written words on write strobes and hands them to the coax transmitter.
// Sequences the bus direction and enforces half-duplex operation: no transmit while a receive is active.
//
// PARAMETERS
// SYNC_STAGES     2   flops in each host strobe synchronizer (>=2)
// FIFO_DEPTH      4   RX word FIFO depth; power of 2, >=2
// TIMEOUT_CYCLES  64  max clk cycles a host strobe may stay high (BUS_TIMEOUT_EN only)
//
// PORTS
// clk                in   1   system clock (19 MHz PLL output)
// reset_n            in   1   asynchronous active-low reset
// rx_data            in   10  received word from coax_rx
// rx_data_available  in   1   coax_rx holds an unread word
// rx_data_read       out  1   1-cycle pulse: word accepted from coax_rx
// rx_active          in   1   coax_rx currently receiving
// tx_data            out  10  word to transmitter; valid while tx_load high
// tx_load            out  1   1-cycle pulse: transmitter takes tx_data
// tx_ready           in   1   transmitter can accept a word
// bus_rd             in   1   host read strobe, asynchronous, active high
// bus_wr             in   1   host write strobe, asynchronous, active high
// bus_data_in        in   10  host bus input path
// bus_data_out       out  10  host bus output path
// bus_data_oe        out  1   drive enable for bus_data_out (pad tristate)
// bus_rx_ready       out  1   FIFO non-empty
// bus_tx_busy        out  1   host word captured, not yet loaded into transmitter
// bus_error          out  1   sticky error flag
//
// BEHAVIOUR
// - Reset: all outputs 0; FIFO emptied; FSM in IDLE; synchronizers cleared. Async assert drops bus_data_oe immediately.
// - Strobes pass through SYNC_STAGES flops; FSM acts on the synced rising/falling edge.
// - RX drain runs independently of the FSM. When rx_data_available=1, FIFO not full and no read pulse in the previous
//   cycle: pulse rx_data_read and push rx_data that same cycle. FIFO full: no read; the word stays in coax_rx, no loss.
// - A simultaneous push and pop on a full FIFO is allowed; count is unchanged.
// - FSM states: IDLE, RD_DRIVE, WR_LOAD, WR_RELEASE.
// - IDLE: synced bus_rd and bus_wr rise in the same cycle -> set bus_error, ignore both, stay IDLE.
// - IDLE, rd rise, FIFO non-empty -> RD_DRIVE: bus_data_out = FIFO head, bus_data_oe=1 next cycle.
// - IDLE, rd rise, FIFO empty -> RD_DRIVE: drive 10'h000, set bus_error, no pop on exit.
// - RD_DRIVE, synced bus_rd falls -> pop (if non-empty at entry), oe=0, go IDLE.
//   bus_data_out is held stable for the whole drive.
// - IDLE, wr rise -> register bus_data_in, bus_tx_busy=1, go WR_LOAD.
//   Host holds data stable for the whole strobe.
// - WR_LOAD: when tx_ready=1 and rx_active=0 -> tx_load pulse, bus_tx_busy=0, go WR_RELEASE.
//   rx_active=1 defers the load (half-duplex).
// - WR_RELEASE: synced bus_wr falls -> IDLE. Strobe already low on entry -> IDLE next cycle.
// - Strobe edges arriving outside IDLE are ignored; a new transaction needs a fresh rise in IDLE.
// - bus_error clears only on reset.
//
// CONFIGURATION
// COAX_BUS_TIMEOUT_EN defined:
// - Counter runs in RD_DRIVE and WR_RELEASE.
// - Strobe still high after TIMEOUT_CYCLES -> oe=0, no pop, set bus_error, go IDLE.
// - The strobe must fall before a new rise is accepted.
// Not defined: FSM waits indefinitely; no counter logic is synthesized.
//
// STRUCTURE
// - coax_pkg: WORD_WIDTH=10, FSM state encoding constants.
// - Sub-module coax_word_fifo: sync FIFO, WORD_WIDTH x FIFO_DEPTH, push/pop/full/empty/head,
//   pointers with an extra wrap bit.
// - This file holds the synchronizers, RX drain logic and FSM.
//
// TESTING
// 1. Three words offered by the coax_rx model; host reads three times -> 3 rx_data_read pulses;
//    bus returns the words in order; oe at SYNC_STAGES+1 cycles after pin rise.
// 2. Five words offered, no host reads (depth 4) -> 4 accepted; 5th left pending with
//    rx_data_available held; one host read -> 5th accepted.
// 3. Host writes 10'h2A5, tx_ready=0 for 10 cycles -> bus_tx_busy held;
//    then tx_ready=1 -> tx_data=10'h2A5 with a single tx_load pulse.
// 4. Write while rx_active=1 -> no tx_load until rx_active falls.
// 5. Host read with FIFO empty -> bus_data_out=10'h000, bus_error=1. Simultaneous rd/wr rise -> bus_error, no state change.
// 6. COAX_BUS_TIMEOUT_EN: bus_rd held 100 cycles -> oe drops at TIMEOUT_CYCLES, FIFO unchanged, bus_error=1.
//    Also assert reset_n mid-RD_DRIVE -> oe=0 at once, FIFO empty.

Source files
------------

// File: rtl/coax_pkg.sv
// coax_pkg: word width and state encoding shared by the coax host bus controller files.
package coax_pkg;

  localparam int WORD_WIDTH = 10;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_RD_DRIVE   = 2'd1,
    ST_WR_LOAD    = 2'd2,
    ST_WR_RELEASE = 2'd3
  } bus_state_t;

endpackage

// File: rtl/coax_word_fifo.sv
// coax_word_fifo: synchronous word FIFO with a combinational head and wrap-bit pointers.
module coax_word_fifo
  import coax_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  push,
  input  logic [WORD_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output logic [WORD_WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [WORD_WIDTH-1:0] mem [DEPTH];
  logic [AW:0]           wr_ptr_reg;
  logic [AW:0]           rd_ptr_reg;
  logic                  do_push;
  logic                  do_pop;

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign head  = mem[rd_ptr_reg[AW-1:0]];

  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/coax_bus_ctrl.sv
// coax_bus_ctrl: half-duplex host bus sequencer between an MCU and the coax RX/TX datapaths.
// Optional strobe watchdog enabled by defining COAX_BUS_TIMEOUT_EN.
module coax_bus_ctrl
  import coax_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
`ifdef COAX_BUS_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 64
`endif
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [WORD_WIDTH-1:0] rx_data,
  input  logic                  rx_data_available,
  output logic                  rx_data_read,
  input  logic                  rx_active,
  output logic [WORD_WIDTH-1:0] tx_data,
  output logic                  tx_load,
  input  logic                  tx_ready,
  input  logic                  bus_rd,
  input  logic                  bus_wr,
  input  logic [WORD_WIDTH-1:0] bus_data_in,
  output logic [WORD_WIDTH-1:0] bus_data_out,
  output logic                  bus_data_oe,
  output logic                  bus_rx_ready,
  output logic                  bus_tx_busy,
  output logic                  bus_error
);

  logic [SYNC_STAGES-1:0] rd_sync_reg, wr_sync_reg;
  logic                   rd_prev_reg, wr_prev_reg;
  logic                   rd_synced, wr_synced, rd_rise, rd_fall, wr_rise;

  logic                   run_reg, read_prev_reg;
  logic                   fifo_full, fifo_empty, fifo_pop;
  logic [WORD_WIDTH-1:0]  fifo_head;

  bus_state_t             state_reg, state_next;
  logic [WORD_WIDTH-1:0]  data_out_reg, data_out_next;
  logic [WORD_WIDTH-1:0]  tx_data_reg, tx_data_next;
  logic                   oe_reg, oe_next;
  logic                   had_data_reg, had_data_next;
  logic                   busy_reg, busy_next;
  logic                   error_reg, error_next;
  logic                   tx_load_reg, tx_load_next;
  logic                   timed_out;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_sync_reg <= '0;
      wr_sync_reg <= '0;
      rd_prev_reg <= 1'b0;
      wr_prev_reg <= 1'b0;
    end else begin
      rd_sync_reg <= {rd_sync_reg[SYNC_STAGES-2:0], bus_rd};
      wr_sync_reg <= {wr_sync_reg[SYNC_STAGES-2:0], bus_wr};
      rd_prev_reg <= rd_synced;
      wr_prev_reg <= wr_synced;
    end
  end

  assign rd_synced = rd_sync_reg[SYNC_STAGES-1];
  assign wr_synced = wr_sync_reg[SYNC_STAGES-1];
  assign rd_rise   = rd_synced && !rd_prev_reg;
  assign rd_fall   = !rd_synced && rd_prev_reg;
  assign wr_rise   = wr_synced && !wr_prev_reg;

  // RX drain: at most one accept every other cycle so coax_rx can present its next word.
  assign rx_data_read = run_reg && rx_data_available && !fifo_full && !read_prev_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_reg       <= 1'b0;
      read_prev_reg <= 1'b0;
    end else begin
      run_reg       <= 1'b1;
      read_prev_reg <= rx_data_read;
    end
  end

  coax_word_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (rx_data_read),
    .push_data(rx_data),
    .pop      (fifo_pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (fifo_head)
  );

`ifdef COAX_BUS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] timer_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer_reg <= '0;
    end else if (state_reg == ST_RD_DRIVE || state_reg == ST_WR_RELEASE) begin
      if (!timed_out) timer_reg <= timer_reg + 1'b1;
    end else begin
      timer_reg <= '0;
    end
  end

  assign timed_out = (timer_reg == TW'(TIMEOUT_CYCLES - 1));
`else
  assign timed_out = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= ST_IDLE;
      data_out_reg <= '0;
      tx_data_reg  <= '0;
      oe_reg       <= 1'b0;
      had_data_reg <= 1'b0;
      busy_reg     <= 1'b0;
      error_reg    <= 1'b0;
      tx_load_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      data_out_reg <= data_out_next;
      tx_data_reg  <= tx_data_next;
      oe_reg       <= oe_next;
      had_data_reg <= had_data_next;
      busy_reg     <= busy_next;
      error_reg    <= error_next;
      tx_load_reg  <= tx_load_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    data_out_next = data_out_reg;
    tx_data_next  = tx_data_reg;
    oe_next       = oe_reg;
    had_data_next = had_data_reg;
    busy_next     = busy_reg;
    error_next    = error_reg;
    tx_load_next  = 1'b0;
    fifo_pop      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (rd_rise && wr_rise) begin
          error_next = 1'b1;
        end else if (rd_rise) begin
          // An empty read still completes a bus cycle, driving zero and flagging the error.
          state_next    = ST_RD_DRIVE;
          oe_next       = 1'b1;
          data_out_next = fifo_empty ? '0 : fifo_head;
          had_data_next = !fifo_empty;
          if (fifo_empty) error_next = 1'b1;
        end else if (wr_rise) begin
          state_next   = ST_WR_LOAD;
          tx_data_next = bus_data_in;
          busy_next    = 1'b1;
        end
      end
      ST_RD_DRIVE: begin
        if (rd_fall) begin
          fifo_pop   = had_data_reg;
          oe_next    = 1'b0;
          state_next = ST_IDLE;
        end else if (timed_out) begin
          oe_next    = 1'b0;
          error_next = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_WR_LOAD: begin
        if (tx_ready && !rx_active) begin
          tx_load_next = 1'b1;
          busy_next    = 1'b0;
          state_next   = ST_WR_RELEASE;
        end
      end
      ST_WR_RELEASE: begin
        if (!wr_synced) begin
          state_next = ST_IDLE;
        end else if (timed_out) begin
          error_next = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign bus_data_out = data_out_reg;
  assign bus_data_oe  = oe_reg;
  assign bus_rx_ready = !fifo_empty;
  assign bus_tx_busy  = busy_reg;
  assign bus_error    = error_reg;
  assign tx_data      = tx_data_reg;
  assign tx_load      = tx_load_reg;

endmodule

// File: tb/tb_coax_bus_ctrl.sv
// tb_coax_bus_ctrl: directed vector table plus hand-written corner sequences for coax_bus_ctrl.
// Define COAX_BUS_TIMEOUT_EN for both bench and RTL to exercise the strobe watchdog.
module tb_coax_bus_ctrl;

  localparam int SYNC = 2;
`ifdef COAX_BUS_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic [9:0] rx_data;
  logic       rx_data_available, rx_data_read, rx_active;
  logic [9:0] tx_data;
  logic       tx_load, tx_ready;
  logic       bus_rd, bus_wr;
  logic [9:0] bus_data_in, bus_data_out;
  logic       bus_data_oe, bus_rx_ready, bus_tx_busy, bus_error;

  always #5 clk = ~clk;

  coax_bus_ctrl #(
    .SYNC_STAGES(SYNC),
    .FIFO_DEPTH (4)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .rx_data          (rx_data),
    .rx_data_available(rx_data_available),
    .rx_data_read     (rx_data_read),
    .rx_active        (rx_active),
    .tx_data          (tx_data),
    .tx_load          (tx_load),
    .tx_ready         (tx_ready),
    .bus_rd           (bus_rd),
    .bus_wr           (bus_wr),
    .bus_data_in      (bus_data_in),
    .bus_data_out     (bus_data_out),
    .bus_data_oe      (bus_data_oe),
    .bus_rx_ready     (bus_rx_ready),
    .bus_tx_busy      (bus_tx_busy),
    .bus_error        (bus_error)
  );

  // coax_rx model: offers rx_words[0..rx_cnt-1] in order, advancing on each accepted read.
  logic [9:0] rx_words [8];
  logic [3:0] rx_cnt;
  logic [3:0] rx_idx;
  int         read_pulses;
  int         load_cnt;
  logic [9:0] last_tx;

  assign rx_data           = rx_words[rx_idx[2:0]];
  assign rx_data_available = (rx_idx < rx_cnt);

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_idx      <= '0;
      read_pulses <= 0;
      load_cnt    <= 0;
      last_tx     <= '0;
    end else begin
      if (rx_data_read) begin
        rx_idx      <= rx_idx + 1'b1;
        read_pulses <= read_pulses + 1;
      end
      if (tx_load) begin
        load_cnt <= load_cnt + 1;
        last_tx  <= tx_data;
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    rx_cnt = '0; bus_rd = 1'b0; bus_wr = 1'b0; bus_data_in = '0;
    tx_ready = 1'b0; rx_active = 1'b0;
    cycles(2);
    reset_n = 1'b1;
    cycles(1);
  endtask

  task automatic host_read(input logic [9:0] exp_data, input string tag);
    int lat;
    lat = 0;
    bus_rd = 1'b1;
    while (!bus_data_oe && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_oe_latency"}, lat, SYNC + 1);
    check({tag, "_data"}, bus_data_out, exp_data);
    cycles(2);
    check({tag, "_data_hold"}, bus_data_out, exp_data);
    bus_rd = 1'b0;
    cycles(4);
    check({tag, "_oe_off"}, bus_data_oe, 1'b0);
    $display("read  %s: data=%03h latency=%0d", tag, exp_data, lat);
  endtask

  task automatic host_write(input logic [9:0] d, input string tag);
    int base, n;
    base = load_cnt;
    n = 0;
    bus_data_in = d;
    bus_wr = 1'b1;
    while (load_cnt == base && n < 30) begin
      @(negedge clk);
      n++;
    end
    cycles(2);
    check({tag, "_load_pulses"}, load_cnt - base, 1);
    check({tag, "_tx_data"}, last_tx, d);
    bus_wr = 1'b0;
    cycles(4);
    $display("write %s: data=%03h", tag, d);
  endtask

  typedef struct {
    bit         is_wr;
    logic [9:0] data;
    bit         exp_err;
    string      tag;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{1'b0, 10'h101, 1'b0, "rd0"};
    vecs[1] = '{1'b0, 10'h2F0, 1'b0, "rd1"};
    vecs[2] = '{1'b0, 10'h0AB, 1'b0, "rd2"};
    vecs[3] = '{1'b1, 10'h2A5, 1'b0, "wr0"};
    vecs[4] = '{1'b1, 10'h15A, 1'b0, "wr1"};
    vecs[5] = '{1'b0, 10'h000, 1'b1, "rd_empty"};

    reset_n = 1'b0;
    rx_cnt = '0; bus_rd = 1'b0; bus_wr = 1'b0; bus_data_in = '0;
    tx_ready = 1'b0; rx_active = 1'b0;
    for (int i = 0; i < 8; i++) rx_words[i] = '0;
    cycles(3);
    check("reset_flags", {bus_data_oe, rx_data_read, tx_load, bus_tx_busy, bus_error, bus_rx_ready}, 6'b0);
    check("reset_bus_data_out", bus_data_out, 10'h000);
    check("reset_tx_data", tx_data, 10'h000);
    reset_n = 1'b1;
    cycles(1);

    // Three words drained, then the vector table.
    rx_words[0] = 10'h101; rx_words[1] = 10'h2F0; rx_words[2] = 10'h0AB;
    rx_cnt = 4'd3;
    cycles(10);
    check("drain3_pulses", read_pulses, 3);
    check("drain3_rx_ready", bus_rx_ready, 1'b1);
    tx_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].is_wr) host_write(vecs[i].data, vecs[i].tag);
      else host_read(vecs[i].data, vecs[i].tag);
      check({vecs[i].tag, "_error"}, bus_error, vecs[i].exp_err);
    end
    check("table_rx_ready_empty", bus_rx_ready, 1'b0);

    // FIFO full: fifth word must stay pending in coax_rx until a pop.
    do_reset();
    for (int i = 0; i < 5; i++) rx_words[i] = 10'(17 * (i + 1));
    rx_cnt = 4'd5;
    cycles(20);
    check("full_pulses", read_pulses, 4);
    check("full_no_read", rx_data_read, 1'b0);
    host_read(10'h011, "full_rd0");
    check("full_fifth_accepted", read_pulses, 5);
    for (int i = 1; i < 5; i++) host_read(10'(17 * (i + 1)), $sformatf("full_rd%0d", i));
    check("full_error", bus_error, 1'b0);

    // Transmitter not ready: busy holds, then one load pulse.
    @(negedge clk);
    tx_ready = 1'b0;
    bus_data_in = 10'h2A5;
    bus_wr = 1'b1;
    cycles(4);
    check("txwait_busy_set", bus_tx_busy, 1'b1);
    cycles(10);
    check("txwait_busy_held", bus_tx_busy, 1'b1);
    check("txwait_no_load", load_cnt, 0);
    tx_ready = 1'b1;
    cycles(3);
    check("txwait_load", load_cnt, 1);
    check("txwait_tx_data", last_tx, 10'h2A5);
    check("txwait_busy_clear", bus_tx_busy, 1'b0);
    cycles(5);
    check("txwait_single_pulse", load_cnt, 1);
    bus_wr = 1'b0;
    cycles(4);
    $display("write txwait: data=2a5");

    // Half-duplex: rx_active defers the load.
    rx_active = 1'b1;
    bus_data_in = 10'h133;
    bus_wr = 1'b1;
    cycles(12);
    check("hdx_no_load", load_cnt, 1);
    check("hdx_busy", bus_tx_busy, 1'b1);
    rx_active = 1'b0;
    cycles(3);
    check("hdx_load", load_cnt, 2);
    check("hdx_tx_data", last_tx, 10'h133);
    bus_wr = 1'b0;
    cycles(4);
    check("hdx_error", bus_error, 1'b0);
    $display("write hdx: data=133");

    // Simultaneous rd/wr rise: error, nothing else happens.
    do_reset();
    check("simul_error_pre", bus_error, 1'b0);
    bus_rd = 1'b1;
    bus_wr = 1'b1;
    cycles(5);
    check("simul_error", bus_error, 1'b1);
    check("simul_oe", bus_data_oe, 1'b0);
    check("simul_busy", bus_tx_busy, 1'b0);
    bus_rd = 1'b0;
    bus_wr = 1'b0;
    cycles(4);
    $display("simul rd/wr: error=%0b", bus_error);
    tx_ready = 1'b1;
    host_write(10'h3C3, "post_simul_wr");

    // Asynchronous reset in the middle of a read drive.
    do_reset();
    rx_words[0] = 10'h1E1;
    rx_cnt = 4'd1;
    cycles(6);
    bus_rd = 1'b1;
    cycles(4);
    check("arst_oe_before", bus_data_oe, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_oe_dropped", bus_data_oe, 1'b0);
    check("arst_fifo_empty", bus_rx_ready, 1'b0);
    rx_cnt = '0;
    bus_rd = 1'b0;
    cycles(2);
    reset_n = 1'b1;
    cycles(1);
    $display("async reset mid-read: oe=%0b", bus_data_oe);

    // Long read strobe: watchdog drops oe after 64 cycles when enabled, else drive persists.
    do_reset();
    rx_words[0] = 10'h0F0;
    rx_cnt = 4'd1;
    cycles(6);
    bus_rd = 1'b1;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (n == 66) check("hold_oe_66", bus_data_oe, 1'b1);
      if (n == 67) check("hold_oe_67", bus_data_oe, !TO_EN);
      if (n == 100) check("hold_error", bus_error, TO_EN);
    end
    check("hold_fifo_kept", bus_rx_ready, 1'b1);
    bus_rd = 1'b0;
    cycles(4);
    check("hold_after_release", bus_rx_ready, TO_EN);
    $display("long read strobe: watchdog=%0b", TO_EN);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
